alu_integrity_monitor: RTL and testbench

Runtime checker on the 16-bit ALU's output boundary. It samples the ALU operands and opcode, recomputes the golden result one cycle later, and compares it with the ALU's registered outputs. It also tracks a leaky count of rare trigger-class operand patterns. Mismatches, suspicious pattern density and the first corrupted transaction are reported to the SoC security/debug logic.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_golden_model.sv | 60 ++++++
 rtl/alu_integrity_monitor.sv | 198 +++++++++++++++++++
 tb/tb_alu_integrity_monitor.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg
// Shared definitions for the ALU checkers: the default datapath width,
// the 2-bit opcode encodings, the integrity-monitor state encodings and
// a packed flag bundle produced by the golden reference model.
package alu_pkg;

    localparam int WIDTH_DEFAULT = 16;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_SUSPECT = 2'b01;
    localparam logic [1:0] ST_ALARM   = 2'b10;

    typedef struct packed {
        logic carry;
        logic zero;
        logic overflow;
        logic negative;
    } alu_flags_t;

endpackage

// File: rtl/alu_golden_model.sv
// alu_golden_model
// Purely combinational reference for the 16-bit ALU, shared by every
// checker that needs an independent opinion of what the ALU should output.
//
// Ports:
//   i_a, i_b    operands
//   i_op        opcode (ADD, SUB, AND, OR)
//   o_result    expected result
//   o_flags     expected {carry, zero, overflow, negative}
module alu_golden_model
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    output logic [WIDTH-1:0] o_result,
    output alu_flags_t       o_flags
);

    logic [WIDTH:0]   w_wide;
    logic [WIDTH-1:0] w_result;
    logic             w_carry;
    logic             w_overflow;

    // For SUB the extra top bit of the widened difference is the borrow,
    // which the ALU reports as its carry flag.
    always_comb begin
        w_wide     = '0;
        w_result   = '0;
        w_carry    = 1'b0;
        w_overflow = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_wide     = {1'b0, i_a} + {1'b0, i_b};
                w_result   = w_wide[WIDTH-1:0];
                w_carry    = w_wide[WIDTH];
                w_overflow = (i_a[WIDTH-1] == i_b[WIDTH-1]) &&
                             (w_wide[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_wide     = {1'b0, i_a} - {1'b0, i_b};
                w_result   = w_wide[WIDTH-1:0];
                w_carry    = w_wide[WIDTH];
                w_overflow = (i_a[WIDTH-1] != i_b[WIDTH-1]) &&
                             (w_wide[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND:  w_result = i_a & i_b;
            default: w_result = i_a | i_b;
        endcase
    end

    assign o_result         = w_result;
    assign o_flags.carry    = w_carry;
    assign o_flags.zero     = (w_result == '0);
    assign o_flags.overflow = w_overflow;
    assign o_flags.negative = w_result[WIDTH-1];

endmodule

// File: rtl/alu_integrity_monitor.sv
// alu_integrity_monitor
// Runtime checker sitting on the ALU output boundary. Operands are staged
// on the edge the ALU computes, and on the following edge the golden result
// is compared with the ALU's registered outputs. It also keeps a leaky count
// of all-ones operand pairs and raises SUSPECT / ALARM for the SoC.
//
// Ports:
//   clk, rst_n            clock shared with the ALU, async active-low reset
//   i_in_valid            operands/opcode valid this cycle
//   i_a, i_b, i_op        operands and opcode as presented to the ALU
//   i_dut_*               ALU registered result and flags
//   i_clear               synchronous clear of counters, capture and FSM
//   o_state               00 IDLE, 01 SUSPECT, 10 ALARM
//   o_alarm, o_suspect    decoded state
//   o_mismatch_count      saturating mismatch count
//   o_rare_count          leaky all-ones pattern count
//   o_cap_*               operands, opcode, golden and observed result of
//                         the first mismatch, qualified by o_cap_valid
module alu_integrity_monitor
    import alu_pkg::*;
#(
    parameter int WIDTH           = WIDTH_DEFAULT,
    parameter int MISMATCH_THRESH = 1,
    parameter int RARE_THRESH     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_dut_result,
    input  logic             i_dut_carry,
    input  logic             i_dut_zero,
    input  logic             i_dut_overflow,
    input  logic             i_dut_negative,
    input  logic             i_clear,
    output logic [1:0]       o_state,
    output logic             o_alarm,
    output logic             o_suspect,
    output logic [7:0]       o_mismatch_count,
    output logic [4:0]       o_rare_count,
    output logic             o_cap_valid,
    output logic [WIDTH-1:0] o_cap_a,
    output logic [WIDTH-1:0] o_cap_b,
    output logic [1:0]       o_cap_op,
    output logic [WIDTH-1:0] o_cap_expected,
    output logic [WIDTH-1:0] o_cap_observed
);

    localparam logic [7:0] MM_TH   = 8'(MISMATCH_THRESH);
    localparam logic [4:0] RARE_TH = 5'(RARE_THRESH);

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [1:0]       r_op;
    logic             r_chk_pend;
    logic [1:0]       r_state;
    logic [7:0]       r_mm_count;
    logic [4:0]       r_rare_count;
    logic             r_cap_valid;
    logic [WIDTH-1:0] r_cap_a;
    logic [WIDTH-1:0] r_cap_b;
    logic [1:0]       r_cap_op;
    logic [WIDTH-1:0] r_cap_expected;
    logic [WIDTH-1:0] r_cap_observed;

    logic [WIDTH-1:0] w_gold_result;
    alu_flags_t       w_gold_flags;
    alu_flags_t       w_dut_flags;
    logic             w_mismatch;
    logic             w_rare_hit;
    logic [7:0]       w_mm_next;
    logic [4:0]       w_rare_next;
    logic [1:0]       w_state_next;

    alu_golden_model #(
        .WIDTH (WIDTH)
    ) u_golden (
        .i_a      (r_a),
        .i_b      (r_b),
        .i_op     (r_op),
        .o_result (w_gold_result),
        .o_flags  (w_gold_flags)
    );

    assign w_dut_flags.carry    = i_dut_carry;
    assign w_dut_flags.zero     = i_dut_zero;
    assign w_dut_flags.overflow = i_dut_overflow;
    assign w_dut_flags.negative = i_dut_negative;

    assign w_mismatch = r_chk_pend &&
                        ((w_gold_result != i_dut_result) || (w_gold_flags != w_dut_flags));
    assign w_rare_hit = i_in_valid && (&i_a) && (&i_b);

    // Post-update counts feed the FSM so that the state always agrees with
    // the counts visible in the same cycle.
    always_comb begin
        w_mm_next = r_mm_count;
        if (w_mismatch && (r_mm_count != 8'hFF)) begin
            w_mm_next = r_mm_count + 8'd1;
        end

        w_rare_next = r_rare_count;
        if (w_rare_hit) begin
            if (r_rare_count != 5'd31) begin
                w_rare_next = r_rare_count + 5'd1;
            end
        end else if (i_in_valid && (r_rare_count != 5'd0)) begin
            w_rare_next = r_rare_count - 5'd1;
        end

        w_state_next = r_state;
        if (w_mm_next >= MM_TH) begin
            w_state_next = ST_ALARM;
        end else if (r_state == ST_IDLE) begin
            if ((w_rare_next >= RARE_TH) || (w_mm_next != 8'd0)) begin
                w_state_next = ST_SUSPECT;
            end
        end else if (r_state == ST_SUSPECT) begin
            if ((w_rare_next < RARE_TH) && (w_mm_next == 8'd0)) begin
                w_state_next = ST_IDLE;
            end
        end
    end

    // Stage 1: hold the operands the ALU consumed this edge so they can be
    // checked against its registered outputs on the next edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_op       <= OP_ADD;
            r_chk_pend <= 1'b0;
        end else if (i_clear) begin
            r_chk_pend <= 1'b0;
        end else begin
            r_chk_pend <= i_in_valid;
            if (i_in_valid) begin
                r_a  <= i_a;
                r_b  <= i_b;
                r_op <= i_op;
            end
        end
    end

    // Counters and FSM; clear overrides any check or rare sample this cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_mm_count   <= 8'd0;
            r_rare_count <= 5'd0;
        end else if (i_clear) begin
            r_state      <= ST_IDLE;
            r_mm_count   <= 8'd0;
            r_rare_count <= 5'd0;
        end else begin
            r_state      <= w_state_next;
            r_mm_count   <= w_mm_next;
            r_rare_count <= w_rare_next;
        end
    end

    // Only the first mismatch after reset/clear is captured; later ones are
    // counted but must not disturb the forensic record.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cap_valid    <= 1'b0;
            r_cap_a        <= '0;
            r_cap_b        <= '0;
            r_cap_op       <= OP_ADD;
            r_cap_expected <= '0;
            r_cap_observed <= '0;
        end else if (i_clear) begin
            r_cap_valid <= 1'b0;
        end else if (w_mismatch && !r_cap_valid) begin
            r_cap_valid    <= 1'b1;
            r_cap_a        <= r_a;
            r_cap_b        <= r_b;
            r_cap_op       <= r_op;
            r_cap_expected <= w_gold_result;
            r_cap_observed <= i_dut_result;
        end
    end

    assign o_state          = r_state;
    assign o_alarm          = (r_state == ST_ALARM);
    assign o_suspect        = (r_state == ST_SUSPECT);
    assign o_mismatch_count = r_mm_count;
    assign o_rare_count     = r_rare_count;
    assign o_cap_valid      = r_cap_valid;
    assign o_cap_a          = r_cap_a;
    assign o_cap_b          = r_cap_b;
    assign o_cap_op         = r_cap_op;
    assign o_cap_expected   = r_cap_expected;
    assign o_cap_observed   = r_cap_observed;

endmodule

// File: tb/tb_alu_integrity_monitor.sv
// tb_alu_integrity_monitor
// Drives a behavioural registered ALU (with a fault-injection mask) and the
// integrity monitor side by side. Every valid operation pushes an item to
// a scoreboard; the item is popped on the edge the monitor delivers its
// verdict and the bench's own model of counts, FSM and capture is compared.
module tb_alu_integrity_monitor;

    localparam int W  = 16;
    localparam int MT = 1;
    localparam int RT = 8;

    localparam logic [1:0] IDLE    = 2'b00;
    localparam logic [1:0] SUSPECT = 2'b01;
    localparam logic [1:0] ALARM   = 2'b10;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          inValid = 1'b0;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic [1:0]    op = 2'b00;
    logic          clear = 1'b0;
    logic [19:0]   injectMask = '0;
    logic [19:0]   aluOut = '0;

    logic [1:0]    state;
    logic          alarm;
    logic          suspect;
    logic [7:0]    mmCount;
    logic [4:0]    rareCount;
    logic          capValid;
    logic [W-1:0]  capA;
    logic [W-1:0]  capB;
    logic [1:0]    capOp;
    logic [W-1:0]  capExp;
    logic [W-1:0]  capObs;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [1:0]   op;
        logic [W-1:0] expRes;
        logic [W-1:0] obsRes;
        bit           bad;
    } item_t;

    item_t         sb[$];

    int            checks = 0;
    int            failures = 0;
    int            expMm = 0;
    int            expRare = 0;
    logic [1:0]    expState = IDLE;
    bit            expCapValid = 1'b0;
    logic [W-1:0]  expCapA = '0;
    logic [W-1:0]  expCapB = '0;
    logic [1:0]    expCapOp = '0;
    logic [W-1:0]  expCapExp = '0;
    logic [W-1:0]  expCapObs = '0;
    logic [W-1:0]  firstSatA = '0;

    alu_integrity_monitor #(
        .WIDTH           (W),
        .MISMATCH_THRESH (MT),
        .RARE_THRESH     (RT)
    ) dut (
        .clk              (clk),
        .rst_n            (rstN),
        .i_in_valid       (inValid),
        .i_a              (a),
        .i_b              (b),
        .i_op             (op),
        .i_dut_result     (aluOut[19:4]),
        .i_dut_carry      (aluOut[3]),
        .i_dut_zero       (aluOut[2]),
        .i_dut_overflow   (aluOut[1]),
        .i_dut_negative   (aluOut[0]),
        .i_clear          (clear),
        .o_state          (state),
        .o_alarm          (alarm),
        .o_suspect        (suspect),
        .o_mismatch_count (mmCount),
        .o_rare_count     (rareCount),
        .o_cap_valid      (capValid),
        .o_cap_a          (capA),
        .o_cap_b          (capB),
        .o_cap_op         (capOp),
        .o_cap_expected   (capExp),
        .o_cap_observed   (capObs)
    );

    always #5 clk = ~clk;

    // Reference ALU computed with integer arithmetic: {result, c, z, v, n}.
    function automatic logic [19:0] goldenRef(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic [1:0] o);
        int ux, uy, sx, sy, u, s;
        logic [W-1:0] r;
        logic c, v;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        s = 0;
        c = 1'b0;
        case (o)
            2'b00:   begin u = ux + uy; s = sx + sy; c = (u > 65535); end
            2'b01:   begin u = ux - uy; s = sx - sy; c = (ux < uy); end
            2'b10:   u = ux & uy;
            default: u = ux | uy;
        endcase
        r = u[15:0];
        v = (o == 2'b00 || o == 2'b01) && (s > 32767 || s < -32768);
        return {r, c, (r == 16'h0000), v, r[15]};
    endfunction

    function automatic logic [1:0] nextState(input logic [1:0] st, input int mm, input int rare);
        if (mm >= MT) return ALARM;
        if (st == ALARM) return ALARM;
        if (st == IDLE) return ((rare >= RT) || (mm >= 1)) ? SUSPECT : IDLE;
        return ((rare < RT) && (mm == 0)) ? IDLE : SUSPECT;
    endfunction

    // Behavioural ALU: registers its result on every valid edge.
    always @(posedge clk) begin
        if (inValid) aluOut <= goldenRef(a, b, op) ^ injectMask;
    end

    task automatic resetModel();
        sb.delete();
        expMm = 0;
        expRare = 0;
        expState = IDLE;
        expCapValid = 1'b0;
    endtask

    // One clock: drive at the falling edge, update the model and compare
    // one time unit after the rising edge, return at the next falling edge.
    task automatic applyStimulus(input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [1:0] o, input logic [19:0] mask, input bit clr);
        item_t item;
        logic [19:0] g;
        logic [19:0] obs;
        inValid = v;
        a = x;
        b = y;
        op = o;
        injectMask = mask;
        clear = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            resetModel();
        end else begin
            if (sb.size() > 0) begin
                item = sb.pop_front();
                if (item.bad) begin
                    if (expMm < 255) expMm++;
                    if (!expCapValid) begin
                        expCapValid = 1'b1;
                        expCapA = item.a;
                        expCapB = item.b;
                        expCapOp = item.op;
                        expCapExp = item.expRes;
                        expCapObs = item.obsRes;
                    end
                end
            end
            if (v) begin
                g = goldenRef(x, y, o);
                obs = g ^ mask;
                item.a = x;
                item.b = y;
                item.op = o;
                item.expRes = g[19:4];
                item.obsRes = obs[19:4];
                item.bad = (mask != 20'h0);
                sb.push_back(item);
                if (x == 16'hFFFF && y == 16'hFFFF) begin
                    if (expRare < 31) expRare++;
                end else if (expRare > 0) begin
                    expRare--;
                end
            end
            expState = nextState(expState, expMm, expRare);
        end
        checkOutput();
        @(negedge clk);
        inValid = 1'b0;
        clear = 1'b0;
        injectMask = '0;
    endtask

    task automatic checkOutput();
        checks++;
        if (mmCount !== expMm[7:0]) begin
            failures++;
            $display("[TB] FAIL mismatch_count actual=%0d required=%0d at %0t", mmCount, expMm, $time);
        end
        checks++;
        if (rareCount !== expRare[4:0]) begin
            failures++;
            $display("[TB] FAIL rare_count actual=%0d required=%0d at %0t", rareCount, expRare, $time);
        end
        checks++;
        if (state !== expState) begin
            failures++;
            $display("[TB] FAIL state actual=%b required=%b at %0t", state, expState, $time);
        end
        checks++;
        if (alarm !== (expState == ALARM) || suspect !== (expState == SUSPECT)) begin
            failures++;
            $display("[TB] FAIL alarm_suspect actual=%b%b required=%b%b at %0t", alarm, suspect,
                     (expState == ALARM), (expState == SUSPECT), $time);
        end
        checks++;
        if (capValid !== expCapValid) begin
            failures++;
            $display("[TB] FAIL cap_valid actual=%b required=%b at %0t", capValid, expCapValid, $time);
        end
        if (expCapValid) begin
            checks++;
            if (capA !== expCapA || capB !== expCapB || capOp !== expCapOp ||
                capExp !== expCapExp || capObs !== expCapObs) begin
                failures++;
                $display("[TB] FAIL capture actual=%h/%h/%b/%h/%h required=%h/%h/%b/%h/%h at %0t",
                         capA, capB, capOp, capExp, capObs,
                         expCapA, expCapB, expCapOp, expCapExp, expCapObs, $time);
            end
        end
    endtask

    task automatic idle();
        applyStimulus(1'b0, '0, '0, 2'b00, '0, 1'b0);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (state !== IDLE || alarm !== 1'b0 || suspect !== 1'b0 || mmCount !== 8'd0 ||
            rareCount !== 5'd0 || capValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_status actual=%b%b%b/%0d/%0d/%b required=000/0/0/0",
                     state, alarm, suspect, mmCount, rareCount, capValid);
        end
        checks++;
        if (capA !== '0 || capB !== '0 || capOp !== 2'b00 || capExp !== '0 || capObs !== '0) begin
            failures++;
            $display("[TB] FAIL reset_capture actual=%h/%h/%b/%h/%h required=all zero",
                     capA, capB, capOp, capExp, capObs);
        end
        @(negedge clk);
        rstN = 1'b1;
        resetModel();
        idle();
    endtask

    task automatic test_clean_random();
        applyStimulus(1'b1, 16'h1234, 16'h0001, 2'b00, '0, 1'b0);
        idle();
        checks++;
        if (mmCount !== 8'd0 || state !== IDLE) begin
            failures++;
            $display("[TB] FAIL clean_add actual=%0d/%b required=0/00", mmCount, state);
        end
        for (int i = 0; i < 1000; i++) begin
            applyStimulus($urandom_range(0, 4) != 0, 16'($urandom), 16'($urandom),
                          2'($urandom_range(0, 3)), '0, 1'b0);
        end
        idle();
        checks++;
        if (mmCount !== 8'd0 || state !== IDLE) begin
            failures++;
            $display("[TB] FAIL clean_random actual=%0d/%b required=0/00", mmCount, state);
        end
    endtask

    task automatic test_mismatch_capture();
        applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 2'b00, 20'h00010, 1'b0);
        checks++;
        if (alarm !== 1'b0) begin
            failures++;
            $display("[TB] FAIL alarm_early actual=%b required=0", alarm);
        end
        idle();
        checks++;
        if (alarm !== 1'b1 || capExp !== 16'hFFFE || capObs !== 16'hFFFF || capOp !== 2'b00) begin
            failures++;
            $display("[TB] FAIL first_capture actual=%b/%h/%h/%b required=1/fffe/ffff/00",
                     alarm, capExp, capObs, capOp);
        end
    endtask

    task automatic test_clear_same_cycle();
        applyStimulus(1'b1, 16'h0001, 16'h0002, 2'b01, 20'h00010, 1'b0);
        applyStimulus(1'b0, '0, '0, 2'b00, '0, 1'b1);
        checks++;
        if (state !== IDLE || mmCount !== 8'd0 || rareCount !== 5'd0 || capValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_wins actual=%b/%0d/%0d/%b required=00/0/0/0",
                     state, mmCount, rareCount, capValid);
        end
        idle();
        checks++;
        if (mmCount !== 8'd0 || capValid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL clear_residue actual=%0d/%b required=0/0", mmCount, capValid);
        end
    endtask

    task automatic test_rare();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'hFFFF, 16'hFFFF, 2'($urandom_range(0, 3)), '0, 1'b0);
            if (i == 6) begin
                checks++;
                if (suspect !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL rare_seven_suspect actual=%b required=0", suspect);
                end
            end
        end
        checks++;
        if (rareCount !== 5'd8 || suspect !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rare_eight actual=%0d/%b required=8/1", rareCount, suspect);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 16'h00AA, 16'h0F0F, 2'($urandom_range(0, 3)), '0, 1'b0);
        end
        idle();
        checks++;
        if (rareCount !== 5'd0 || state !== IDLE) begin
            failures++;
            $display("[TB] FAIL rare_drain actual=%0d/%b required=0/00", rareCount, state);
        end
    endtask

    task automatic test_back_to_back_saturation();
        firstSatA = 16'h5A5A;
        applyStimulus(1'b1, firstSatA, 16'h0101, 2'b10, 20'h00010, 1'b0);
        for (int i = 1; i < 300; i++) begin
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)),
                          20'h00010, 1'b0);
        end
        idle();
        checks++;
        if (mmCount !== 8'd255 || alarm !== 1'b1 || capA !== firstSatA || capOp !== 2'b10) begin
            failures++;
            $display("[TB] FAIL saturation actual=%0d/%b/%h/%b required=255/1/%h/10",
                     mmCount, alarm, capA, capOp, firstSatA);
        end
    endtask

    task automatic test_reset_mid_alarm();
        applyStimulus(1'b1, 16'h0005, 16'h0006, 2'b00, 20'h00010, 1'b0);
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (state !== IDLE || alarm !== 1'b0 || mmCount !== 8'd0 || rareCount !== 5'd0 ||
            capValid !== 1'b0 || capA !== '0 || capExp !== '0 || capObs !== '0) begin
            failures++;
            $display("[TB] FAIL reset_mid_alarm actual=%b/%b/%0d/%0d/%b/%h/%h/%h required=zeros",
                     state, alarm, mmCount, rareCount, capValid, capA, capExp, capObs);
        end
        @(negedge clk);
        rstN = 1'b1;
        resetModel();
        idle();
        applyStimulus(1'b1, 16'h1234, 16'h0001, 2'b00, '0, 1'b0);
        idle();
        checks++;
        if (mmCount !== 8'd0 || state !== IDLE) begin
            failures++;
            $display("[TB] FAIL post_reset_clean actual=%0d/%b required=0/00", mmCount, state);
        end
        applyStimulus(1'b1, 16'h0007, 16'h0003, 2'b01, 20'h00001, 1'b0);
        idle();
        checks++;
        if (mmCount !== 8'd1 || alarm !== 1'b1 || capExp !== 16'h0004 || capObs !== 16'h0004 ||
            capOp !== 2'b01) begin
            failures++;
            $display("[TB] FAIL post_reset_flag actual=%0d/%b/%h/%h/%b required=1/1/0004/0004/01",
                     mmCount, alarm, capExp, capObs, capOp);
        end
    endtask

    initial begin
        test_reset();
        test_clean_random();
        test_mismatch_capture();
        test_clear_same_cycle();
        test_rare();
        test_back_to_back_saturation();
        test_reset_mid_alarm();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
